instr_mem_fetch: RTL

Parametrised instruction memory with a pipelined fetch port and a runtime load port; the successor to the fixed 32×32 asynchronous-read instruction ROM. It sits between the PC/fetch logic and the decode stage. It accepts word-addressed fetch requests over a valid/ready handshake and returns instructions through a small response buffer. The buffer supports back-pressure from decode and a flush for taken branches and jumps. Program words are loaded at runtime through a write port, not hard-coded.

---
 rtl/imem_pkg.sv | 15 +
 rtl/imem_rsp_fifo.sv | 62 ++++++
 rtl/instr_mem_fetch.sv | 132 +++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared defaults and the response layout for the instruction memory fetch block.
package imem_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

   localparam logic [DEF_DATA_W-1:0] NOP_WORD = 32'h0000_0000;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic                  fault;
      logic [DEF_DATA_W-1:0] data;
   } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Show-ahead response FIFO with a synchronous clear; the head entry is always visible on o_data.
module imem_rsp_fifo #(
   parameter int WIDTH = 38,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_store [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_store[i] <= '0;
         end
      end else if (i_clear) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_store[r_wrPtr] <= i_data;
            r_wrPtr          <= nextPtr(r_wrPtr);
         end
         if (i_pop) begin
            r_rdPtr <= nextPtr(r_rdPtr);
         end
         r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
      end
   end

   assign o_valid = (r_count != '0);
   assign o_data  = r_store[r_rdPtr];

   // The upstream credit counter makes both of these unreachable.
   assert property (@(posedge clk) disable iff (rst) !(i_push && (r_count == FULL_CNT)));
   assert property (@(posedge clk) disable iff (rst) !(i_pop && (r_count == '0)));

endmodule

// File: rtl/instr_mem_fetch.sv
// Loadable instruction memory with a credit-controlled pipelined fetch port and buffered responses.
module instr_mem_fetch
   import imem_pkg::*;
#(
   parameter int                DATA_W   = DEF_DATA_W,
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter int                DEPTH    = 32,
   parameter int                READ_LAT = 1,
   parameter logic [DATA_W-1:0] NOP_WORD = imem_pkg::NOP_WORD
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_fault,
   input  logic              flush,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int FIFO_D = READ_LAT + 1;
   localparam int CNT_W  = $clog2(FIFO_D + 1);
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int ENT_W  = ADDR_W + 1 + DATA_W;
   localparam logic [ADDR_W:0]  DEPTH_V = (ADDR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] CREDITS = CNT_W'(FIFO_D);

   logic [DATA_W-1:0]   r_mem [DEPTH];
   logic [READ_LAT-1:0] r_pipeValid;
   logic [READ_LAT-1:0] r_pipeFault;
   logic [ADDR_W-1:0]   r_pipeAddr [READ_LAT];
   logic [DATA_W-1:0]   r_pipeData [READ_LAT];
   logic [CNT_W-1:0]    r_outstanding;
   logic                r_readyEn;

   logic              w_accept;
   logic              w_reqFault;
   logic              w_wrInRange;
   logic              w_push;
   logic              w_pop;
   logic              w_rspValid;
   logic [DATA_W-1:0] w_tailData;
   logic [ENT_W-1:0]  w_pushEntry;
   logic [ENT_W-1:0]  w_headEntry;

   assign w_reqFault  = ({1'b0, req_addr} >= DEPTH_V);
   assign w_wrInRange = ({1'b0, wr_addr} < DEPTH_V);

   // A flush empties everything at this edge, so the redirect request is always admitted.
   assign req_ready = r_readyEn & (flush | (r_outstanding < CREDITS));
   assign w_accept  = req_valid & req_ready;
   assign w_pop     = w_rspValid & rsp_ready & ~flush;
   assign w_push    = r_pipeValid[READ_LAT-1] & ~flush;

   // Array and data path carry no reset so the memory maps onto block RAM and survives rst.
   always_ff @(posedge clk) begin
      if (wr_en && w_wrInRange) begin
         r_mem[wr_addr[MEM_AW-1:0]] <= wr_data;
      end
      if (w_accept) begin
         r_pipeData[0] <= r_mem[req_addr[MEM_AW-1:0]];
      end
      for (int i = 1; i < READ_LAT; i++) begin
         r_pipeData[i] <= r_pipeData[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pipeValid <= '0;
         r_pipeFault <= '0;
         for (int i = 0; i < READ_LAT; i++) begin
            r_pipeAddr[i] <= '0;
         end
      end else begin
         r_pipeValid[0] <= w_accept;
         if (w_accept) begin
            r_pipeAddr[0]  <= req_addr;
            r_pipeFault[0] <= w_reqFault;
         end
         for (int i = 1; i < READ_LAT; i++) begin
            r_pipeValid[i] <= r_pipeValid[i-1] & ~flush;
            r_pipeAddr[i]  <= r_pipeAddr[i-1];
            r_pipeFault[i] <= r_pipeFault[i-1];
         end
      end
   end

   // Outstanding count covers both pipeline stages and buffered responses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outstanding <= '0;
         r_readyEn     <= 1'b0;
      end else begin
         r_readyEn <= 1'b1;
         if (flush) begin
            r_outstanding <= CNT_W'(w_accept);
         end else begin
            r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(w_pop);
         end
      end
   end

   assert property (@(posedge clk) disable iff (rst) r_outstanding <= CREDITS);

   assign w_tailData  = r_pipeFault[READ_LAT-1] ? NOP_WORD : r_pipeData[READ_LAT-1];
   assign w_pushEntry = {r_pipeAddr[READ_LAT-1], r_pipeFault[READ_LAT-1], w_tailData};

   imem_rsp_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (FIFO_D)
   ) u_rspFifo (
      .clk     (clk),
      .rst     (rst),
      .i_clear (flush),
      .i_push  (w_push),
      .i_data  (w_pushEntry),
      .i_pop   (w_pop),
      .o_valid (w_rspValid),
      .o_data  (w_headEntry)
   );

   assign rsp_valid = w_rspValid;
   assign {rsp_addr, rsp_fault, rsp_data} = w_headEntry;

endmodule
